// File: rtl/frame_update_scheduler_pkg.sv
// rtl/frame_update_scheduler_pkg.sv - shared types and helpers for the frame update scheduler
package frame_update_scheduler_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

  // Sprite index width; a two-sprite build still gets a one-bit index.
  function automatic int sprite_idx_w(input int num_sprites);
    return (num_sprites > 2) ? $clog2(num_sprites) : 1;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// rtl/edge_rise_det.sv - registered rising-edge detector
// Pulses for the first cycle a level-high input is seen; shared with button debouncing.
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame round-robin update slot sequencer
// Divides frame edges, then grants one req/ack slot to each sprite with a rotating start.
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int  NUM_SPRITES = 4,
  parameter int  TIMEOUT     = 63,
  parameter int  FRAME_DIV   = 1,
  localparam int IDX_W       = sprite_idx_w(NUM_SPRITES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame,
  input  logic [NUM_SPRITES-1:0] upd_ack,
  input  logic                   clr_err,
  output logic [NUM_SPRITES-1:0] upd_req,
  output logic [IDX_W-1:0]       upd_idx,
  output logic                   busy,
  output logic                   seq_done,
  output logic [NUM_SPRITES-1:0] timeout_flags,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_SPRITES - 1);
  localparam logic [7:0]             WAIT_LIMIT = 8'(TIMEOUT);
  localparam logic [3:0]             DIV_LAST   = 4'(FRAME_DIV - 1);
  localparam logic [NUM_SPRITES-1:0] REQ_ONE    = NUM_SPRITES'(1);

  sched_state_e           state_q;
  logic [IDX_W-1:0]       cur_q;
  logic [IDX_W-1:0]       start_idx_q;
  logic [IDX_W-1:0]       n_q;
  logic [7:0]             wait_cnt_q;
  logic [NUM_SPRITES-1:0] upd_req_q;
  logic [IDX_W-1:0]       upd_idx_q;
  logic                   busy_q;
  logic                   seq_done_q;
  logic [NUM_SPRITES-1:0] timeout_flags_q;
  logic                   overrun_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [FRAME_CNT_W-1:0] frame_count_d;
  logic [3:0]             div_cnt_q;
  logic [3:0]             div_cnt_d;
  logic                   frame_edge;
  logic                   launch;
  logic [IDX_W-1:0]       cur_next;

  // Explicit wrap so non-power-of-two sprite counts rotate correctly.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  edge_rise_det u_frame_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (frame),
    .rise_o (frame_edge)
  );

  assign cur_next = wrap_inc(cur_q);

  always_comb begin
    frame_count_d = frame_count_q;
    div_cnt_d     = div_cnt_q;
    launch        = 1'b0;
    if (frame_edge) begin
      frame_count_d = frame_count_q + 1'b1;
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        launch    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
      div_cnt_q     <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      div_cnt_q     <= div_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cur_q           <= '0;
      start_idx_q     <= '0;
      n_q             <= '0;
      wait_cnt_q      <= '0;
      upd_req_q       <= '0;
      upd_idx_q       <= '0;
      busy_q          <= 1'b0;
      seq_done_q      <= 1'b0;
      timeout_flags_q <= '0;
      overrun_q       <= 1'b0;
    end else begin
      seq_done_q <= 1'b0;
      // Clears are issued first so a same-cycle set below takes precedence.
      if (clr_err) begin
        overrun_q       <= 1'b0;
        timeout_flags_q <= '0;
      end
      if (launch && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q    <= ST_REQ;
            cur_q      <= start_idx_q;
            n_q        <= '0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b1;
            upd_req_q  <= REQ_ONE << start_idx_q;
            upd_idx_q  <= start_idx_q;
          end
        end
        ST_REQ: begin
          if (upd_ack[cur_q]) begin
            state_q   <= ST_GAP;
            upd_req_q <= '0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            state_q                <= ST_GAP;
            upd_req_q              <= '0;
            timeout_flags_q[cur_q] <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (n_q == LAST_IDX) begin
            state_q    <= ST_DONE;
            seq_done_q <= 1'b1;
          end else begin
            state_q    <= ST_REQ;
            cur_q      <= cur_next;
            n_q        <= n_q + 1'b1;
            wait_cnt_q <= '0;
            upd_req_q  <= REQ_ONE << cur_next;
            upd_idx_q  <= cur_next;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          start_idx_q <= wrap_inc(start_idx_q);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign upd_req       = upd_req_q;
  assign upd_idx       = upd_idx_q;
  assign busy          = busy_q;
  assign seq_done      = seq_done_q;
  assign timeout_flags = timeout_flags_q;
  assign overrun       = overrun_q;
  assign frame_count   = frame_count_q;

endmodule
